// File: rtl/pf_sched_pkg.sv
// Shared types and widths for the prefetch/demand memory request scheduler.
package pf_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int ADDR_W = 16;
  localparam int DROP_W = 8;

endpackage

// File: rtl/pf_queue.sv
// Circular prefetch queue with per-entry valid bits; all entries are exposed
// so the scheduler can compare addresses for dedup and demand invalidation.
module pf_queue
  import pf_sched_pkg::*;
#(
  parameter int QLOG2 = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic [ADDR_W-1:0]                     push_addr,
  input  logic                                  pop,
  input  logic [(1<<QLOG2)-1:0]                 inval,
  output logic [(1<<QLOG2)-1:0]                 ent_valid,
  output logic [(1<<QLOG2)-1:0][ADDR_W-1:0]     ent_addr,
  output logic                                  head_valid,
  output logic [ADDR_W-1:0]                     head_addr,
  output logic                                  full,
  output logic                                  advance,
  output logic [QLOG2:0]                        count
);

  localparam int DEPTH = 1 << QLOG2;
  localparam int CW    = QLOG2 + 1;

  logic [CW-1:0]                 head_reg, tail_reg, count_reg, used;
  logic [DEPTH-1:0]              valid_reg, valid_next;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_reg;
  logic [QLOG2-1:0]              head_idx, tail_idx;
  logic                          slots_empty;

  assign head_idx    = head_reg[QLOG2-1:0];
  assign tail_idx    = tail_reg[QLOG2-1:0];
  assign used        = tail_reg - head_reg;
  assign slots_empty = (used == '0);
  assign full        = (used == CW'(DEPTH));
  assign head_valid  = !slots_empty && valid_reg[head_idx];
  assign head_addr   = addr_reg[head_idx];
  // An invalidated head slot is retired on its own, without needing a grant.
  assign advance     = !slots_empty && (pop || !valid_reg[head_idx]);
  assign ent_valid   = valid_reg;
  assign ent_addr    = addr_reg;
  assign count       = count_reg;

  always_comb begin
    valid_next = valid_reg & ~inval;
    if (advance) valid_next[head_idx] = 1'b0;
    if (push)    valid_next[tail_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      if (advance) head_reg <= head_reg + CW'(1);
      if (push)    tail_reg <= tail_reg + CW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop && head_valid) - CW'(|inval);
    end
  end

  always_ff @(posedge clk) begin
    if (push) addr_reg[tail_idx] <= push_addr;
  end

endmodule

// File: rtl/pf_sched.sv
// Arbitrates demand requests against queued prefetches onto a single-outstanding
// memory request port, with starvation protection for the prefetch queue.
module pf_sched
  import pf_sched_pkg::*;
#(
  parameter int QLOG2      = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dem_v,
  input  logic [ADDR_W-1:0] dem_addr,
  output logic              dem_ready,
  input  logic              pf_v,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic              mem_req_v,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_pf,
  input  logic              mem_req_ready,
  input  logic              mem_resp_v,
  output logic [QLOG2:0]    pf_count,
  output logic [DROP_W-1:0] pf_drops
);

  localparam int DEPTH = 1 << QLOG2;
  localparam int SW    = $clog2(STARVE_LIM + 1);

  state_t                       state_reg;
  logic [ADDR_W-1:0]            req_addr_reg;
  logic                         req_pf_reg, req_v_reg;
  logic [SW-1:0]                starve_reg;
  logic [DROP_W-1:0]            drops_reg;

  logic [DEPTH-1:0]             ent_valid, inval, hit;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic                         head_valid, full, advance;
  logic [ADDR_W-1:0]            head_addr;
  logic                         force_pf, dem_grant, pf_grant, dup, push, drop;

  assign force_pf  = head_valid && (starve_reg == SW'(STARVE_LIM - 1));
  assign dem_grant = (state_reg == IDLE) && dem_v && !force_pf;
  assign pf_grant  = (state_reg == IDLE) && head_valid && !dem_grant;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign inval[gi] = dem_grant && ent_valid[gi] && (ent_addr[gi] == dem_addr);
      assign hit[gi]   = ent_valid[gi] && (ent_addr[gi] == pf_addr);
    end
  endgenerate

  // A candidate is redundant if already queued, in flight, or being demanded now.
  assign dup  = (|hit)
              || ((state_reg != IDLE) && (pf_addr == req_addr_reg))
              || (dem_grant && (pf_addr == dem_addr));
  assign push = pf_v && !dup && (!full || advance);
  assign drop = pf_v && !dup && full && !advance;

  pf_queue #(.QLOG2(QLOG2)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (pf_addr),
    .pop        (pf_grant),
    .inval      (inval),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .full       (full),
    .advance    (advance),
    .count      (pf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_addr_reg <= '0;
      req_pf_reg   <= 1'b0;
      req_v_reg    <= 1'b0;
      starve_reg   <= '0;
      drops_reg    <= '0;
    end else begin
      if (drop && (drops_reg != '1)) drops_reg <= drops_reg + DROP_W'(1);

      if (pf_grant || (pf_count == '0))
        starve_reg <= '0;
      else if (dem_grant && (starve_reg != SW'(STARVE_LIM - 1)))
        starve_reg <= starve_reg + SW'(1);

      case (state_reg)
        IDLE: begin
          if (dem_grant || pf_grant) begin
            req_addr_reg <= dem_grant ? dem_addr : head_addr;
            req_pf_reg   <= pf_grant;
            req_v_reg    <= 1'b1;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            req_v_reg <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_v) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dem_ready    = dem_grant;
  assign mem_req_v    = req_v_reg;
  assign mem_req_addr = req_addr_reg;
  assign mem_req_pf   = req_pf_reg;
  assign pf_drops     = drops_reg;

endmodule

// File: tb/tb_pf_sched.sv
// Directed self-checking bench for pf_sched: inputs change 1 ns after posedge,
// outputs are checked 2 ns after posedge.
module tb_pf_sched;

  logic        clk = 1'b0;
  logic        rst, dem_v, pf_v, mem_req_ready, mem_resp_v;
  logic [15:0] dem_addr, pf_addr, mem_req_addr;
  logic        dem_ready, mem_req_v, mem_req_pf;
  logic [2:0]  pf_count;
  logic [7:0]  pf_drops;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pf_sched #(.QLOG2(2), .STARVE_LIM(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .dem_v         (dem_v),
    .dem_addr      (dem_addr),
    .dem_ready     (dem_ready),
    .pf_v          (pf_v),
    .pf_addr       (pf_addr),
    .mem_req_v     (mem_req_v),
    .mem_req_addr  (mem_req_addr),
    .mem_req_pf    (mem_req_pf),
    .mem_req_ready (mem_req_ready),
    .mem_resp_v    (mem_resp_v),
    .pf_count      (pf_count),
    .pf_drops      (pf_drops)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after a grant (FSM in ISSUE); returns in IDLE.
  task automatic serve();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_v = 1'b1;
    step();
    mem_resp_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dem_v = 1'b0; dem_addr = '0; pf_v = 1'b0; pf_addr = '0;
    mem_req_ready = 1'b0; mem_resp_v = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_mem_req_v", 32'(mem_req_v), 32'd0);
    chk("rst_mem_req_addr", 32'(mem_req_addr), 32'd0);
    chk("rst_mem_req_pf", 32'(mem_req_pf), 32'd0);
    chk("rst_dem_ready", 32'(dem_ready), 32'd0);
    chk("rst_pf_count", 32'(pf_count), 32'd0);
    chk("rst_pf_drops", 32'(pf_drops), 32'd0);

    // Basic demand: ready in grant cycle, request the cycle after.
    step();
    dem_v = 1'b1; dem_addr = 16'h0040;
    #1;
    chk("dem_ready_c1", 32'(dem_ready), 32'd1);
    chk("mem_req_v_c1", 32'(mem_req_v), 32'd0);
    step();
    dem_v = 1'b0;
    #1;
    chk("mem_req_v_c2", 32'(mem_req_v), 32'd1);
    chk("mem_req_addr_c2", 32'(mem_req_addr), 32'h0040);
    chk("mem_req_pf_c2", 32'(mem_req_pf), 32'd0);
    step();
    chk("issue_hold_v", 32'(mem_req_v), 32'd1);
    chk("issue_hold_addr", 32'(mem_req_addr), 32'h0040);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    dem_v = 1'b1; dem_addr = 16'h0041;
    #1;
    chk("wait_mem_req_v", 32'(mem_req_v), 32'd0);
    chk("wait_dem_ready", 32'(dem_ready), 32'd0);
    dem_v = 1'b0;
    mem_resp_v = 1'b1;
    step();
    mem_resp_v = 1'b0;
    dem_v = 1'b1; dem_addr = 16'h0041;
    #1;
    chk("idle_again_dem_ready", 32'(dem_ready), 32'd1);
    dem_v = 1'b0;

    // Candidate equal to the demand accepted this cycle, then equal to the in-flight address.
    step();
    dem_v = 1'b1; dem_addr = 16'h0070; pf_v = 1'b1; pf_addr = 16'h0070;
    step();
    dem_v = 1'b0;
    step();
    pf_v = 1'b0;
    #1;
    chk("dup_demand_pf_count", 32'(pf_count), 32'd0);
    serve();

    // Fill the queue while a demand is held in ISSUE.
    dem_v = 1'b1; dem_addr = 16'h0100;
    step();
    dem_v = 1'b0;
    pf_v = 1'b1; pf_addr = 16'h0010; step();
    pf_addr = 16'h0020; step();
    pf_addr = 16'h0010; step();
    pf_v = 1'b0;
    #1;
    chk("dedup_pf_count", 32'(pf_count), 32'd2);
    chk("dedup_pf_drops", 32'(pf_drops), 32'd0);
    pf_v = 1'b1; pf_addr = 16'h0030; step();
    pf_addr = 16'h0040; step();
    pf_addr = 16'h0050; step();
    pf_v = 1'b0;
    #1;
    chk("full_pf_count", 32'(pf_count), 32'd4);
    chk("full_pf_drops", 32'(pf_drops), 32'd1);
    pf_v = 1'b1; pf_addr = 16'h0020; step();
    pf_v = 1'b0;
    #1;
    chk("full_dup_no_drop", 32'(pf_drops), 32'd1);
    for (int i = 0; i < 300; i++) begin
      pf_v = 1'b1; pf_addr = 16'(16'h1000 + i);
      step();
    end
    pf_v = 1'b0;
    #1;
    chk("drops_saturate", 32'(pf_drops), 32'd255);
    chk("drops_count_held", 32'(pf_count), 32'd4);
    serve();

    // Full queue pops its head while a new candidate arrives: push accepted.
    pf_v = 1'b1; pf_addr = 16'h0060;
    #1;
    chk("pop_cycle_dem_ready", 32'(dem_ready), 32'd0);
    step();
    pf_v = 1'b0;
    #1;
    chk("pf_issue_v", 32'(mem_req_v), 32'd1);
    chk("pf_issue_addr", 32'(mem_req_addr), 32'h0010);
    chk("pf_issue_pf", 32'(mem_req_pf), 32'd1);
    chk("full_pop_push_count", 32'(pf_count), 32'd4);

    // Reset while in ISSUE; stale response ignored.
    rst = 1'b1; step();
    rst = 1'b0;
    #1;
    chk("rst_issue_v", 32'(mem_req_v), 32'd0);
    chk("rst_issue_count", 32'(pf_count), 32'd0);
    chk("rst_issue_drops", 32'(pf_drops), 32'd0);
    mem_resp_v = 1'b1; step();
    mem_resp_v = 1'b0;
    #1;
    chk("rst_issue_stale_resp", 32'(mem_req_v), 32'd0);

    // Starvation: 7 demand grants with 0x30 queued, then the prefetch is forced.
    dem_v = 1'b1; dem_addr = 16'h0200;
    step();
    dem_v = 1'b0;
    pf_v = 1'b1; pf_addr = 16'h0030; step();
    pf_v = 1'b0;
    serve();
    for (int i = 0; i < 7; i++) begin
      dem_v = 1'b1; dem_addr = 16'(16'h0300 + i);
      #1;
      chk("starve_dem_ready", 32'(dem_ready), 32'd1);
      step();
      serve();
    end
    dem_addr = 16'h0307;
    #1;
    chk("starve_forced_dem_ready", 32'(dem_ready), 32'd0);
    step();
    dem_v = 1'b0;
    #1;
    chk("starve_pf_addr", 32'(mem_req_addr), 32'h0030);
    chk("starve_pf_type", 32'(mem_req_pf), 32'd1);
    chk("starve_pf_count", 32'(pf_count), 32'd0);
    serve();

    // Demand to a queued address invalidates it; it is never prefetched.
    dem_v = 1'b1; dem_addr = 16'h0400;
    step();
    dem_v = 1'b0;
    pf_v = 1'b1; pf_addr = 16'h0050; step();
    pf_v = 1'b0;
    #1;
    chk("inval_pre_count", 32'(pf_count), 32'd1);
    serve();
    dem_v = 1'b1; dem_addr = 16'h0050;
    #1;
    chk("inval_dem_ready", 32'(dem_ready), 32'd1);
    step();
    dem_v = 1'b0;
    #1;
    chk("inval_post_count", 32'(pf_count), 32'd0);
    chk("inval_req_addr", 32'(mem_req_addr), 32'h0050);
    chk("inval_req_pf", 32'(mem_req_pf), 32'd0);
    serve();
    step();
    chk("inval_no_prefetch", 32'(mem_req_v), 32'd0);

    // Reset during WAIT, then a stale response.
    dem_v = 1'b1; dem_addr = 16'h0500;
    step();
    dem_v = 1'b0;
    pf_v = 1'b1; pf_addr = 16'h0060; step();
    pf_v = 1'b0;
    mem_req_ready = 1'b1; step();
    mem_req_ready = 1'b0;
    #1;
    chk("wait_pre_rst_count", 32'(pf_count), 32'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    mem_resp_v = 1'b1; step();
    mem_resp_v = 1'b0;
    #1;
    chk("rst_wait_v", 32'(mem_req_v), 32'd0);
    chk("rst_wait_count", 32'(pf_count), 32'd0);
    step();
    chk("rst_wait_v_later", 32'(mem_req_v), 32'd0);
    dem_v = 1'b1; dem_addr = 16'h0600;
    #1;
    chk("rst_wait_idle", 32'(dem_ready), 32'd1);
    dem_v = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
